// File: rtl/iq_polar_pkg.sv
// Shared types, widths and constants for the I/Q to polar CORDIC converter.
package iq_polar_pkg;

    localparam int IN_W  = 14;
    localparam int XY_W  = 18;
    localparam int PH_W  = 16;
    localparam int MAG_W = 15;

    // x/y carry two fraction bits below the input LSB so per-step shift truncation
    // does not pile up in the magnitude; the final scale shifts them back out.
    localparam int GUARD = 2;

    localparam logic [15:0] K_INV_Q15 = 16'd19898;

    typedef enum logic [1:0] {IDLE, ROTATE, SCALE} state_t;

    // atan(2^-i) in units of pi/32768, rounded
    localparam logic [PH_W-1:0] ATAN [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297,
        16'd651,  16'd326,  16'd163,  16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,
        16'd3,    16'd1,    16'd1,    16'd0
    };

    typedef struct packed {
        logic signed [XY_W-1:0] x;
        logic signed [XY_W-1:0] y;
        logic        [PH_W-1:0] z;
    } cordic_vec_t;

endpackage

// File: rtl/iq_polar_converter_step.sv
// One vectoring-mode CORDIC micro-rotation; drives y toward zero, accumulates angle in z.
module cordic_vector_step
    import iq_polar_pkg::*;
(
    input  cordic_vec_t cur,
    input  logic [3:0]  shift,
    output cordic_vec_t nxt
);

    logic signed [XY_W-1:0] cx, cy, xs, ys;

    assign cx = cur.x;
    assign cy = cur.y;
    assign xs = cx >>> shift;
    assign ys = cy >>> shift;

    always_comb begin
        nxt = cur;
        if (!cy[XY_W-1]) begin
            nxt.x = cx + ys;
            nxt.y = cy - xs;
            nxt.z = cur.z + ATAN[shift];
        end else begin
            nxt.x = cx - ys;
            nxt.y = cy + xs;
            nxt.z = cur.z - ATAN[shift];
        end
    end

endmodule

// File: rtl/iq_polar_converter.sv
// Iterative I/Q to magnitude/phase converter: one CORDIC step per cycle, then a gain-scale cycle.
module iq_polar_converter
    import iq_polar_pkg::*;
#(
    parameter int ITER = 14
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  I,
    input  logic signed [IN_W-1:0]  Q,
    output logic                    out_valid,
    output logic [MAG_W-1:0]        mag,
    output logic [PH_W-1:0]         phase,
    output logic                    busy,
    output logic [7:0]              drop_count
);

    state_t      state, state_nxt;
    logic [3:0]  step;
    cordic_vec_t vec, vec_rot, pre;
    logic        zero_in;

    logic signed [XY_W-1:0]   i_ext, q_ext, x_cur;
    logic signed [XY_W+16:0]  prod, prod_sh;
    logic [MAG_W-1:0]         mag_sat;

    cordic_vector_step u_step (
        .cur   (vec),
        .shift (step),
        .nxt   (vec_rot)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = ROTATE;
            end
            ROTATE: if (step == 4'(ITER-1)) state_nxt = SCALE;
            SCALE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Fold the left half-plane onto the right so the iterations always converge.
    assign i_ext = {{(XY_W-IN_W-GUARD){I[IN_W-1]}}, I, {GUARD{1'b0}}};
    assign q_ext = {{(XY_W-IN_W-GUARD){Q[IN_W-1]}}, Q, {GUARD{1'b0}}};

    always_comb begin
        pre = '0;
        if (I[IN_W-1]) begin
            pre.x = -i_ext;
            pre.y = -q_ext;
            pre.z = 16'h8000;
        end else begin
            pre.x = i_ext;
            pre.y = q_ext;
        end
    end

    assign x_cur   = vec.x;
    assign prod    = x_cur * $signed({1'b0, K_INV_Q15});
    assign prod_sh = prod >>> (15 + GUARD);

    always_comb begin
        mag_sat = prod_sh[MAG_W-1:0];
        if (prod_sh[XY_W+16])
            mag_sat = '0;
        else if (|prod_sh[XY_W+15:MAG_W])
            mag_sat = '1;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            step       <= '0;
            vec        <= '0;
            zero_in    <= 1'b0;
            out_valid  <= 1'b0;
            mag        <= '0;
            phase      <= '0;
            drop_count <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            if (in_valid && !in_ready && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            case (state)
                IDLE: if (in_valid) begin
                    vec     <= pre;
                    step    <= '0;
                    zero_in <= (I == '0) && (Q == '0);
                end
                ROTATE: begin
                    vec  <= vec_rot;
                    step <= step + 4'd1;
                end
                SCALE: begin
                    mag       <= mag_sat;
                    // A zero vector has no angle; the accumulated table sum is meaningless.
                    phase     <= zero_in ? '0 : vec.z;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
